// File: rtl/regfile_sched_pkg.sv
// Shared types and sizes for the register-file write-port scheduler.
package regfile_sched_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DATA_W     = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wr_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; last_dbg remembers whether requester 1 won the last transfer.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_dbg;

    // On contention the requester that did not win last time is served.
    always_comb begin
        gnt[0] = req[0] && (!req[1] || last_dbg);
        gnt[1] = req[1] && (!req[0] || !last_dbg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_dbg <= 1'b1;
        else if (advance)
            last_dbg <= gnt[1];
    end
endmodule

// File: rtl/regfile_port_scheduler.sv
// Shares the register-file write port between core and debug writers, plus a zero-fill sweep.
// Build option: REGFILE_DBG_PORT_EN enables the debug port in arbitration.
module regfile_port_scheduler
    import regfile_sched_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    input  logic                  core_valid,
    input  logic [REG_ADDR_W-1:0] core_rd,
    input  logic [WIDTH-1:0]      core_data,
    output logic                  core_ready,
    input  logic                  dbg_valid,
    input  logic [REG_ADDR_W-1:0] dbg_rd,
    input  logic [WIDTH-1:0]      dbg_data,
    output logic                  dbg_ready,
    output logic [REG_ADDR_W-1:0] RD,
    output logic [WIDTH-1:0]      RD_data,
    output logic                  write_en,
    output logic                  busy,
    output logic                  clear_done
);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

    state_t                state, state_next;
    logic [REG_ADDR_W-1:0] idx, idx_next;
    logic [REG_ADDR_W-1:0] rd_next;
    logic [WIDTH-1:0]      data_next;
    logic                  we_n_next;
    logic                  done_next;
    logic                  accept_ok;
    logic                  core_gnt, dbg_gnt, xfer;
    wr_req_t               sel;

    assign accept_ok = (state == IDLE) && !clear_req;

`ifdef REGFILE_DBG_PORT_EN
    logic [1:0] gnt;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({accept_ok && dbg_valid, accept_ok && core_valid}),
        .advance (xfer),
        .gnt     (gnt)
    );

    assign core_gnt = gnt[0];
    assign dbg_gnt  = gnt[1];
`else
    logic unused_dbg;

    assign unused_dbg = ^{dbg_valid, dbg_rd, dbg_data};
    assign core_gnt   = accept_ok && core_valid;
    assign dbg_gnt    = 1'b0;
`endif

    assign xfer       = core_gnt || dbg_gnt;
    assign core_ready = core_gnt;
    assign dbg_ready  = dbg_gnt;
    assign busy       = (state == CLEAR);
    assign sel        = dbg_gnt ? wr_req_t'{rd: dbg_rd, data: dbg_data}
                                : wr_req_t'{rd: core_rd, data: core_data};

    always_comb begin
        state_next = state;
        idx_next   = idx;
        rd_next    = RD;
        data_next  = RD_data;
        we_n_next  = 1'b1;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end else if (xfer && (sel.rd != '0)) begin
                    // x0 is hardwired; accepted writes to it are silently dropped.
                    rd_next   = sel.rd;
                    data_next = sel.data;
                    we_n_next = 1'b0;
                end
            end
            CLEAR: begin
                rd_next   = idx;
                data_next = '0;
                we_n_next = 1'b0;
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output stage: one-cycle write latency to the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            RD         <= '0;
            RD_data    <= '0;
            write_en   <= 1'b1;
            clear_done <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            RD         <= rd_next;
            RD_data    <= data_next;
            write_en   <= we_n_next;
            clear_done <= done_next;
        end
    end
endmodule
